contador_arbitro: RTL and testbench

Sequencer and arbiter that shares one up/down counter (8-bit, acrescer/decrecer step inputs, registered output) between two requesters. Each requester submits a target value. The block grants one request at a time, round-robin. It then steps the counter one unit at a time, rate-limited, until the counter output equals the clamped target, and signals completion to the owner. It sits between user-facing command sources and the counter, and is the only driver of the counter's step inputs.

---
 rtl/contador_arbitro_pkg.sv | 30 +++
 rtl/contador_arbitro_rr.sv | 42 ++++
 rtl/contador_arbitro.sv | 107 ++++++++++
 tb/tb_contador_arbitro.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/contador_arbitro_pkg.sv
// Shared types and constants for the counter sequencer/arbiter.
// Holds the FSM state encoding, the counter width and the target clamp helper.
package contador_arbitro_pkg;

   localparam int CNT_W = 8;
   localparam int N_REQ = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MOVE = 2'd1,
      ST_DONE = 2'd2
   } estado_t;

   function automatic logic [CNT_W-1:0] clamp_alvo(
      input logic [CNT_W-1:0] val,
      input logic [CNT_W-1:0] lo,
      input logic [CNT_W-1:0] hi
   );
      logic [CNT_W-1:0] res;
      if (val < lo) begin
         res = lo;
      end else if (val > hi) begin
         res = hi;
      end else begin
         res = val;
      end
      return res;
   endfunction

endpackage

// File: rtl/contador_arbitro_rr.sv
// Two-way round-robin grant: a tie goes to the requester that was not served last.
// The last-served pointer only moves on the update strobe.
module rr_arbiter2
   import contador_arbitro_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   input  logic             upd,
   input  logic             upd_idx,
   output logic             any,
   output logic             grant
);

   logic pref_r;

   // Preferred requester for a tie; points away from whoever finished last
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pref_r <= 1'b0;
      end else if (upd) begin
         pref_r <= ~upd_idx;
      end else begin
         pref_r <= pref_r;
      end
   end

   // Grant selection from the current request vector
   always_comb begin
      grant = 1'b0;
      if (req == 2'b11) begin
         grant = pref_r;
      end else if (req[1]) begin
         grant = 1'b1;
      end else begin
         grant = 1'b0;
      end
   end

   assign any = |req;

endmodule

// File: rtl/contador_arbitro.sv
// Shares one up/down counter between two requesters: grants round-robin, then
// steps the counter one unit at a time (rate-limited) until it reaches the clamped target.
module contador_arbitro
   import contador_arbitro_pkg::*;
#(
   parameter logic [CNT_W-1:0] LIM_MIN  = 8'd0,
   parameter logic [CNT_W-1:0] LIM_MAX  = 8'd255,
   parameter int               STEP_DIV = 2
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [CNT_W-1:0] contagem,
   input  logic [N_REQ-1:0] req_valid,
   input  logic [CNT_W-1:0] req_alvo0,
   input  logic [CNT_W-1:0] req_alvo1,
   output logic [N_REQ-1:0] req_ready,
   output logic [N_REQ-1:0] done,
   output logic             acrescer,
   output logic             decrecer,
   output logic             busy,
   output logic             dono
);

   localparam int DIV_W = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(STEP_DIV - 1);

   estado_t          state_r;
   logic [CNT_W-1:0] alvo_r;
   logic [DIV_W-1:0] div_r;
   logic             any_s;
   logic             grant_s;
   logic             upd_s;
   logic [CNT_W-1:0] alvo_sel_s;

   assign upd_s      = (state_r == ST_DONE);
   assign alvo_sel_s = grant_s ? req_alvo1 : req_alvo0;

   rr_arbiter2 u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req_valid),
      .upd     (upd_s),
      .upd_idx (dono),
      .any     (any_s),
      .grant   (grant_s)
   );

   // Sequencer FSM; every output is registered here
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= ST_IDLE;
         alvo_r    <= '0;
         div_r     <= '0;
         req_ready <= 2'b00;
         done      <= 2'b00;
         acrescer  <= 1'b0;
         decrecer  <= 1'b0;
         busy      <= 1'b0;
         dono      <= 1'b0;
      end else begin
         req_ready <= 2'b00;
         done      <= 2'b00;
         acrescer  <= 1'b0;
         decrecer  <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (any_s) begin
                  req_ready <= 2'b01 << grant_s;
                  alvo_r    <= clamp_alvo(alvo_sel_s, LIM_MIN, LIM_MAX);
                  dono      <= grant_s;
                  div_r     <= '0;
                  state_r   <= ST_MOVE;
               end else begin
                  state_r   <= ST_IDLE;
               end
            end
            ST_MOVE: begin
               busy <= 1'b1;
               // Live compare against the fed-back count tolerates outside disturbance
               if (contagem == alvo_r) begin
                  state_r <= ST_DONE;
               end else if (div_r == '0) begin
                  if (contagem < alvo_r) begin
                     acrescer <= 1'b1;
                  end else begin
                     decrecer <= 1'b1;
                  end
                  div_r <= DIV_LOAD;
               end else begin
                  div_r <= div_r - 1'b1;
               end
            end
            ST_DONE: begin
               done    <= 2'b01 << dono;
               busy    <= 1'b0;
               div_r   <= '0;
               state_r <= ST_IDLE;
            end
            default: begin
               busy    <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_contador_arbitro.sv
// Self-checking bench: a schedule model predicts every output each cycle, and
// directed scenarios pin step counts, grant order and final counter values.
module tb_contador_arbitro;

   localparam int SD = 2;
   localparam logic [7:0] LO = 8'd50;
   localparam logic [7:0] HI = 8'd200;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] cnt = 8'd0;
   logic [1:0] req_valid;
   logic [7:0] req_alvo0, req_alvo1;
   logic [1:0] req_ready, done;
   logic       acrescer, decrecer, busy, dono;
   logic       load_en;
   logic [7:0] load_val;

   int n_tests = 0, n_fail = 0, cyc = 0;
   int acr_total = 0, dec_total = 0, done0_total = 0, done1_total = 0;
   int ready_cyc = 0, done_cyc = 0;
   int glog[$];

   always #5 clk = ~clk;

   contador_arbitro #(.LIM_MIN(LO), .LIM_MAX(HI), .STEP_DIV(SD)) dut (
      .clk(clk), .rst_n(rst_n), .contagem(cnt), .req_valid(req_valid),
      .req_alvo0(req_alvo0), .req_alvo1(req_alvo1), .req_ready(req_ready),
      .done(done), .acrescer(acrescer), .decrecer(decrecer), .busy(busy), .dono(dono)
   );

   // The shared counter itself; it is not reset by rst_n
   always @(posedge clk) begin
      if (load_en) cnt <= load_val;
      else if (acrescer) cnt <= cnt + 8'd1;
      else if (decrecer) cnt <= cnt - 8'd1;
   end

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   function automatic logic [7:0] outs();
      return {req_ready, done, acrescer, decrecer, busy, dono};
   endfunction

   // Model state: one accepted request is described by its accept cycle,
   // step count and direction; everything else follows arithmetically.
   logic       m_active = 1'b0, m_ptr = 1'b0, m_own = 1'b0, m_up = 1'b0;
   int         m_r = 0, m_n = 0, m_done_c = 0, m_ok = 0;

   always @(posedge clk) begin
      logic [7:0] t, e;
      logic [1:0] e_ready, e_done;
      logic       e_acr, e_dec, e_busy, step;
      int         off;
      #1;
      cyc++;
      if (acrescer) acr_total++;
      if (decrecer) dec_total++;
      if (done[0]) done0_total++;
      if (done[1]) done1_total++;
      if (req_ready != 2'b00) begin ready_cyc = cyc; glog.push_back(req_ready[1] ? 1 : 0); end
      if (done != 2'b00) done_cyc = cyc;
      if (!rst_n) begin
         m_active = 1'b0; m_ptr = 1'b0; m_own = 1'b0; m_ok = 0;
         check("outputs in reset", int'(outs()), 0);
      end else begin
         e_ready = 2'b00; e_done = 2'b00; e_acr = 1'b0; e_dec = 1'b0; e_busy = 1'b0;
         if (!m_active && cyc >= m_ok && req_valid != 2'b00) begin
            m_own = (req_valid == 2'b11) ? m_ptr : req_valid[1];
            t = m_own ? req_alvo1 : req_alvo0;
            t = (t < LO) ? LO : ((t > HI) ? HI : t);
            m_up = (t > cnt);
            m_n = m_up ? int'(t) - int'(cnt) : int'(cnt) - int'(t);
            m_r = cyc;
            m_done_c = (m_n == 0) ? cyc + 2 : cyc + 4 + (m_n - 1) * SD;
            m_active = 1'b1;
         end
         if (m_active) begin
            off = cyc - m_r;
            if (off == 0) e_ready = 2'b01 << m_own;
            step = (off >= 1) && ((off - 1) % SD == 0) && ((off - 1) / SD < m_n);
            e_acr = step && m_up;
            e_dec = step && !m_up;
            e_busy = (off >= 1) && (cyc < m_done_c);
            if (cyc == m_done_c) begin
               e_done = 2'b01 << m_own;
               m_active = 1'b0;
               m_ptr = ~m_own;
               m_ok = cyc + 1;
            end
         end
         e = {e_ready, e_done, e_acr, e_dec, e_busy, m_own};
         check("cycle outputs {ready,done,acr,dec,busy,dono}", int'(outs()), int'(e));
         check("acr/dec exclusive", int'(acrescer & decrecer), 0);
      end
   end

   task automatic load(input logic [7:0] v);
      @(negedge clk); load_en = 1'b1; load_val = v;
      @(negedge clk); load_en = 1'b0;
   endtask

   task automatic serve(input logic [1:0] mask, input logic [7:0] t0, input logic [7:0] t1);
      logic [1:0] pend;
      int d0, want, budget;
      @(negedge clk);
      req_alvo0 = t0; req_alvo1 = t1; req_valid = mask; pend = mask;
      d0 = done0_total + done1_total;
      want = int'(mask[0]) + int'(mask[1]);
      budget = 0;
      while ((pend != 2'b00 || done0_total + done1_total - d0 < want) && budget < 2000) begin
         @(negedge clk);
         budget++;
         for (int b = 0; b < 2; b++) begin
            if (req_ready[b]) begin pend[b] = 1'b0; req_valid[b] = 1'b0; end
         end
      end
      check("serve within cycle budget", int'(budget < 2000), 1);
      req_valid = 2'b00;
   endtask

   initial begin
      int a0, d0, k0, budget;
      rst_n = 1'b0; req_valid = 2'b00; req_alvo0 = 8'd0; req_alvo1 = 8'd0;
      load_en = 1'b0; load_val = 8'd0;
      repeat (2) @(negedge clk);
      check("reset outputs literal", int'(outs()), 0);
      load(8'd106);
      @(negedge clk); rst_n = 1'b1;

      // 106 -> 109 by requester 0
      a0 = acr_total; d0 = dec_total; k0 = done0_total;
      serve(2'b01, 8'd109, 8'd0);
      check("t1 acrescer pulses", acr_total - a0, 3);
      check("t1 decrecer pulses", dec_total - d0, 0);
      check("t1 done0 pulses", done0_total - k0, 1);
      check("t1 counter", int'(cnt), 109);
      check("t1 busy low", int'(busy), 0);

      // 106 -> 100 by requester 1
      load(8'd106);
      d0 = dec_total;
      serve(2'b10, 8'd0, 8'd100);
      check("t2 decrecer pulses", dec_total - d0, 6);
      check("t2 counter", int'(cnt), 100);
      check("t2 dono", int'(dono), 1);

      // Simultaneous pair after reset: requester 0 first
      @(negedge clk); rst_n = 1'b0;
      repeat (2) @(negedge clk);
      load(8'd106);
      @(negedge clk); rst_n = 1'b1;
      glog.delete();
      serve(2'b11, 8'd110, 8'd104);
      check("t3 grants", glog.size(), 2);
      check("t3 first grant", glog[0], 0);
      check("t3 second grant", glog[1], 1);
      check("t3 counter", int'(cnt), 104);

      // Requester 0 served last, so a tie now goes to requester 1
      serve(2'b01, 8'd106, 8'd0);
      serve(2'b11, 8'd108, 8'd106);
      check("t4 tie grant", glog[3], 1);
      check("t4 next grant", glog[4], 0);
      check("t4 counter", int'(cnt), 108);

      // Upper clamp: 250 -> 200
      load(8'd198);
      a0 = acr_total;
      serve(2'b01, 8'd250, 8'd0);
      check("t5 acrescer pulses", acr_total - a0, 2);
      check("t5 counter", int'(cnt), 200);

      // Lower clamp: 10 -> 50
      load(8'd53);
      d0 = dec_total;
      serve(2'b10, 8'd0, 8'd10);
      check("t6 decrecer pulses", dec_total - d0, 3);
      check("t6 counter", int'(cnt), 50);

      // Reset during MOVE after two steps
      load(8'd106);
      a0 = acr_total;
      @(negedge clk); req_alvo0 = 8'd120; req_valid = 2'b01;
      budget = 0;
      while (acr_total - a0 < 2 && budget < 200) begin
         @(negedge clk); budget++;
         if (req_ready[0]) req_valid = 2'b00;
      end
      check("t7 two steps within budget", int'(budget < 200), 1);
      @(negedge clk);
      rst_n = 1'b0; req_valid = 2'b00;
      k0 = done0_total;
      #1;
      check("t7 outputs right after reset", int'(outs()), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      check("t7 no done after reset", done0_total - k0, 0);
      check("t7 counter kept", int'(cnt), 108);
      d0 = dec_total; k0 = done1_total;
      serve(2'b10, 8'd0, 8'd106);
      check("t7 decrecer pulses", dec_total - d0, 2);
      check("t7 done1 pulses", done1_total - k0, 1);
      check("t7 counter", int'(cnt), 106);

      // Target equal to counter: no steps, done two cycles after ready
      a0 = acr_total; d0 = dec_total;
      serve(2'b01, 8'd106, 8'd0);
      check("t8 ready-to-done spacing", done_cyc - ready_cyc, 2);
      check("t8 no steps", (acr_total - a0) + (dec_total - d0), 0);

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
